// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with iterative multiply and optional
// iterative divide. Define ALU_DIV_EN to build the restoring divider for
// opcodes 14/15; otherwise those opcodes complete in one cycle with ERR set.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_SEL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_RES,
  output logic [3:0]       FLAGS,
  output logic             ERR
);

  localparam int unsigned LG = $clog2(WIDTH);
  localparam int unsigned CW = LG + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_SHR  = 4'd9,
    OP_SHL  = 4'd10,
    OP_ASR  = 4'd11,
    OP_ROR  = 4'd12,
    OP_ROL  = 4'd13,
    OP_DIV  = 4'd14,
    OP_REM  = 4'd15
  } op_t;

  state_t state, state_n;
  op_t    op;
  op_t    busy_op;
  logic   accept;
  logic   iter_op;
  logic   last_step;
  logic [CW-1:0] cnt;

  logic [WIDTH-1:0] res_q;
  logic [3:0]       flags_q;
  logic             err_q;

  assign op        = op_t'(ALU_SEL);
  assign IN_READY  = !RST && ((state == IDLE) || ((state == DONE) && OUT_READY));
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = (state == DONE);
  assign last_step = (cnt == CW'(1));
  assign ALU_RES   = res_q;
  assign FLAGS     = flags_q;
  assign ERR       = err_q;

`ifdef ALU_DIV_EN
  assign iter_op = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
  assign iter_op = (op == OP_MUL);
`endif

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  logic [LG-1:0]    amt, amt_m1, amt_neg;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_err;

  assign amt     = B[LG-1:0];
  assign amt_m1  = amt - LG'(1);
  assign amt_neg = '0 - amt;
  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};

  // Result, carry, overflow and error for opcodes finished at the accept edge.
  // Shift carries index A directly: bit amt-1 leaves on right shifts, bit
  // WIDTH-amt leaves on left shifts (amt_neg == WIDTH-amt when amt != 0).
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NAND: sc_res = ~(A & B);
      OP_NOR:  sc_res = ~(A | B);
      OP_XNOR: sc_res = ~(A ^ B);
      OP_SHR: begin
        sc_res = A >> amt;
        sc_c   = (amt != '0) && A[amt_m1];
      end
      OP_SHL: begin
        sc_res = A << amt;
        sc_c   = (amt != '0) && A[amt_neg];
      end
      OP_ASR: begin
        sc_res = $signed(A) >>> amt;
        sc_c   = (amt != '0) && A[amt_m1];
      end
      OP_ROR: begin
        sc_res = (A >> amt) | (A << amt_neg);
        sc_c   = (amt != '0) && A[amt_m1];
      end
      OP_ROL: begin
        sc_res = (A << amt) | (A >> amt_neg);
        sc_c   = (amt != '0) && A[amt_neg];
      end
`ifndef ALU_DIV_EN
      OP_DIV, OP_REM: sc_err = 1'b1;
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative multiplier (shift-add)
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] mul_acc, mul_mc, mul_acc_n;
  logic [WIDTH-1:0]   mul_mp;

  assign mul_acc_n = mul_acc + (mul_mp[0] ? mul_mc : '0);

`ifdef ALU_DIV_EN
  // ---------------------------------------------------------------------
  // Iterative restoring divider; a zero divisor naturally yields an
  // all-ones quotient and a remainder equal to the dividend.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] div_rem, div_quo, div_b;
  logic [WIDTH:0]   div_sh, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n, div_quo_n;

  assign div_sh    = {div_rem, div_quo[WIDTH-1]};
  assign div_ge    = (div_sh >= {1'b0, div_b});
  assign div_sub   = div_sh - {1'b0, div_b};
  assign div_rem_n = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_quo_n = {div_quo[WIDTH-2:0], div_ge};
`endif

  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_err;

  // Result of the final iterative step, registered on the BUSY->DONE edge.
  always_comb begin
    fin_res = mul_acc_n[WIDTH-1:0];
    fin_c   = |mul_acc_n[2*WIDTH-1:WIDTH];
    fin_err = 1'b0;
`ifdef ALU_DIV_EN
    if (busy_op == OP_DIV) begin
      fin_res = div_quo_n;
      fin_c   = 1'b0;
      fin_err = (div_b == '0);
    end else if (busy_op == OP_REM) begin
      fin_res = div_rem_n;
      fin_c   = 1'b0;
      fin_err = (div_b == '0);
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = iter_op ? BUSY : DONE;
      BUSY: if (last_step) state_n = DONE;
      DONE: begin
        if (accept)         state_n = iter_op ? BUSY : DONE;
        else if (OUT_READY) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, iteration steps and result/flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_op <= OP_ADD;
      cnt     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      mul_acc <= '0;
      mul_mc  <= '0;
      mul_mp  <= '0;
`ifdef ALU_DIV_EN
      div_rem <= '0;
      div_quo <= '0;
      div_b   <= '0;
`endif
    end else if (accept) begin
      busy_op <= op;
      if (iter_op) begin
        cnt     <= CW'(WIDTH);
        mul_acc <= '0;
        mul_mc  <= {{WIDTH{1'b0}}, A};
        mul_mp  <= B;
`ifdef ALU_DIV_EN
        div_rem <= '0;
        div_quo <= A;
        div_b   <= B;
`endif
      end else begin
        res_q   <= sc_res;
        flags_q <= {sc_c, sc_v, sc_res[WIDTH-1], (sc_res == '0)};
        err_q   <= sc_err;
      end
    end else if (state == BUSY) begin
      cnt     <= cnt - CW'(1);
      mul_acc <= mul_acc_n;
      mul_mc  <= mul_mc << 1;
      mul_mp  <= mul_mp >> 1;
`ifdef ALU_DIV_EN
      div_rem <= div_rem_n;
      div_quo <= div_quo_n;
`endif
      if (last_step) begin
        res_q   <= fin_res;
        flags_q <= {fin_c, 1'b0, fin_res[WIDTH-1], (fin_res == '0)};
        err_q   <= fin_err;
      end
    end
  end

endmodule
